// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared widths, table address slices and next_pc select encoding
package branch_resolve_unit_pkg;
  localparam int PC_W = 32;
  localparam int IDX_HI = 5;
  localparam int IDX_LO = 2;
  localparam int TAG_HI = 31;
  localparam int TAG_LO = 6;
  typedef enum logic [1:0] {SEL_PC4, SEL_TGT, SEL_REDIR} sel_e;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: fetch, stage-2 and prediction-table signals of the branch resolve unit
interface branch_resolve_unit_if #(parameter int CNT_W = 16);
  logic stall;
  logic [31:0] pc4;
  logic H;
  logic P;
  logic [31:0] Target;
  logic is_beq_s2;
  logic cond_s2;
  logic [31:0] baddr_in_s2;
  logic [31:0] next_pc;
  logic flush;
  logic WRt;
  logic WRp;
  logic C;
  logic [31:0] pc4_s2;
  logic [31:0] baddr_s2;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;
  modport master (
    output stall, pc4, H, P, Target, is_beq_s2, cond_s2, baddr_in_s2,
    input next_pc, flush, WRt, WRp, C, pc4_s2, baddr_s2, br_count, mp_count
  );
  modport slave (
    input stall, pc4, H, P, Target, is_beq_s2, cond_s2, baddr_in_s2,
    output next_pc, flush, WRt, WRp, C, pc4_s2, baddr_s2, br_count, mp_count
  );
endinterface

// File: rtl/branch_resolve_unit_sat_counter.sv
// sat_counter: counter that increments on inc and sticks at all-ones
module sat_counter #(parameter int W = 16) (
  input logic clk,
  input logic reset,
  input logic inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: carries table lookups to stage 2, resolves BEQs, redirects fetch and updates the table
module branch_resolve_unit import branch_resolve_unit_pkg::*; #(
  parameter int CNT_W = 16,
  parameter logic [PC_W-1:0] PC_RESET = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  branch_resolve_unit_if.slave bus
);
  logic valid_s2, h_s2, p_s2;
  logic [PC_W-1:0] tgt_s2, pc4_q, redir;
  logic res, br, mp;
  sel_e sel;
  always_ff @(posedge clk)
    if (reset) begin
      valid_s2 <= 1'b0;
      h_s2 <= 1'b0;
      p_s2 <= 1'b0;
      tgt_s2 <= '0;
      pc4_q <= PC_RESET;
    end else if (mp) valid_s2 <= 1'b0;
    else if (!bus.stall) begin
      valid_s2 <= 1'b1;
      h_s2 <= bus.H;
      p_s2 <= bus.H & bus.P;
      tgt_s2 <= bus.Target;
      pc4_q <= bus.pc4;
    end
  always_comb begin
    res = valid_s2 & ~bus.stall & ~reset;
    br = res & bus.is_beq_s2;
    mp = (br & (p_s2 ? (~bus.cond_s2 | (tgt_s2 != bus.baddr_in_s2)) : bus.cond_s2))
       | (res & ~bus.is_beq_s2 & p_s2);
    redir = (~bus.is_beq_s2 | ~bus.cond_s2) ? pc4_q : bus.baddr_in_s2;
    sel = mp ? SEL_REDIR : (bus.H & bus.P) ? SEL_TGT : SEL_PC4;
  end
  assign bus.next_pc = (sel == SEL_REDIR) ? redir : (sel == SEL_TGT) ? bus.Target : bus.pc4;
  assign bus.flush = mp;
  assign bus.WRt = br & ~h_s2;
  assign bus.WRp = br;
  assign bus.C = br & bus.cond_s2;
  assign bus.pc4_s2 = pc4_q;
  assign bus.baddr_s2 = bus.baddr_in_s2;
  sat_counter #(.W(CNT_W)) u_br (.clk(clk), .reset(reset), .inc(br), .count(bus.br_count));
  sat_counter #(.W(CNT_W)) u_mp (.clk(clk), .reset(reset), .inc(mp), .count(bus.mp_count));
endmodule
